// File: rtl/fifo_get_drain.sv
// Get-side drain stage: fetches words from the token-ring FIFO into a small
// circular buffer and presents them downstream on a valid/ready stream.
module fifo_get_drain #(
    parameter int N_BITS = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk_get,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              empty_in,
    input  logic [N_BITS-1:0] data_get,
    output logic              req_get,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] out_data,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              busy
);

    // state    | meaning
    // ST_IDLE  | no fetching; buffered words still deliverable
    // ST_RUN   | fetching from the FIFO while space allows
    // ST_FLUSH | no fetching, head hidden, waiting for in-flight word to drop

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W:0] FULL_LVL = (OCC_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               inflight;
    logic [N_BITS-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W:0]     occ_pend;
    logic               push;
    logic               pop;

    // Reserve a slot for the in-flight word so the buffer cannot overflow.
    assign occ_pend  = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    assign req_get   = (state == ST_RUN) && !empty_in && (occ_pend < FULL_LVL);
    assign out_valid = (occ != '0) && (state != ST_FLUSH);
    assign out_data  = mem[rd_ptr];
    assign busy      = (state != ST_IDLE) || inflight;
    assign push      = inflight && (state != ST_FLUSH);
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE:  if (enable)    state_nxt = ST_RUN;
                ST_RUN:   if (!enable)   state_nxt = ST_IDLE;
                ST_FLUSH: if (!inflight) state_nxt = ST_IDLE;
                default:                 state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_get) begin
        if (reset) begin
            state    <= ST_IDLE;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            word_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            inflight <= req_get;
            if (pop) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            // Holding the buffer empty for the whole flush leaves it cleared on exit.
            if (state == ST_FLUSH) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= data_get;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    occ <= occ + OCC_W'(1);
                end else if (pop && !push) begin
                    occ <= occ - OCC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_get_drain.sv
// Bench for fifo_get_drain: FIFO behavioural model plus a queue-based
// reference of the drain stage, exercised by directed and random scenarios.
module tb_fifo_get_drain;

    localparam int N_BITS = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;

    logic              clk_get = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              flush = 1'b0;
    logic              empty_in = 1'b1;
    logic [N_BITS-1:0] data_get = '0;
    logic              out_ready = 1'b0;
    logic              req_get;
    logic              out_valid;
    logic [N_BITS-1:0] out_data;
    logic [CNT_W-1:0]  word_cnt;
    logic              busy;

    always #5 clk_get = ~clk_get;

    fifo_get_drain #(.N_BITS(N_BITS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_get  (clk_get),
        .reset    (reset),
        .enable   (enable),
        .flush    (flush),
        .empty_in (empty_in),
        .data_get (data_get),
        .req_get  (req_get),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .word_cnt (word_cnt),
        .busy     (busy)
    );

    int tests = 0;
    int fails = 0;

    logic [N_BITS-1:0] fq[$];
    logic [N_BITS-1:0] mq[$];
    logic [N_BITS-1:0] obs[$];
    logic [N_BITS-1:0] expd[$];
    int                m_state = M_IDLE;
    bit                mfl = 1'b0;
    logic [N_BITS-1:0] mfl_word = '0;
    int                m_cnt = 0;
    bit                hold_empty = 1'b0;
    bit                chk_en = 1'b0;
    int cyc = 0, req_count = 0, first_req = -1, last_req = -1, first_valid = -1;
    int req_err = 0, valid_err = 0, busy_err = 0, cnt_err = 0;

    task automatic clear_stats();
        obs.delete();
        expd.delete();
        req_count = 0; first_req = -1; last_req = -1; first_valid = -1;
        req_err = 0; valid_err = 0; busy_err = 0; cnt_err = 0;
    endtask

    task automatic load(input int n, input logic [N_BITS-1:0] base);
        for (int i = 0; i < n; i++) fq.push_back(base + N_BITS'(i));
        empty_in = hold_empty || (fq.size() == 0);
    endtask

    // One clock cycle: record DUT activity, advance FIFO and reference model.
    task automatic step();
        bit exp_req, exp_valid, exp_busy, fetch;
        int ns;
        logic [N_BITS-1:0] head, fword;
        #1;
        exp_req   = (m_state == M_RUN) && !empty_in && (mq.size() + int'(mfl) < DEPTH);
        exp_valid = (m_state != M_FLUSH) && (mq.size() != 0);
        exp_busy  = (m_state != M_IDLE) || mfl;
        if (chk_en) begin
            if (req_get !== exp_req) req_err++;
            if (out_valid !== exp_valid) valid_err++;
            if (busy !== exp_busy) busy_err++;
            if (word_cnt !== CNT_W'(m_cnt)) cnt_err++;
        end
        if (req_get === 1'b1) begin
            req_count++;
            if (first_req < 0) first_req = cyc;
            last_req = cyc;
        end
        if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
        if (out_valid === 1'b1 && out_ready) obs.push_back(out_data);
        if (exp_valid && out_ready) expd.push_back(mq[0]);
        head  = (fq.size() != 0) ? fq[0] : '0;
        fetch = (req_get === 1'b1) && !empty_in && (fq.size() != 0);
        if (fetch) fword = fq.pop_front();
        else fword = $urandom;
        if (reset) begin
            m_state = M_IDLE; mq.delete(); mfl = 1'b0; m_cnt = 0;
        end else begin
            if (exp_valid && out_ready) begin
                mq.delete(0);
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            if (mfl && m_state != M_FLUSH) mq.push_back(mfl_word);
            ns = m_state;
            if (flush) ns = M_FLUSH;
            else if (m_state == M_IDLE && enable) ns = M_RUN;
            else if (m_state == M_RUN && !enable) ns = M_IDLE;
            else if (m_state == M_FLUSH && !mfl) ns = M_IDLE;
            if (m_state == M_FLUSH) mq.delete();
            mfl = exp_req;
            if (exp_req) mfl_word = head;
            m_state = ns;
        end
        @(posedge clk_get);
        #1;
        cyc++;
        data_get = fword;
        empty_in = hold_empty || (fq.size() == 0);
        if (reset) chk_en = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
        load(3, 32'h0000_0F00);
        for (int k = 0; k < 2; k++) begin
            step();
            tests++; if (req_get !== 1'b0) begin fails++; $display("FAIL reset_req got=%0b exp=0", req_get); end
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
            tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_data got=%0h exp=0", out_data); end
            tests++; if (word_cnt !== '0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", word_cnt); end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        end
        reset = 1'b0;
        #1;
        tests++; if (req_get !== 1'b0) begin fails++; $display("FAIL reset_release_req got=%0b exp=0", req_get); end
        step();
        tests++; if (req_get !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_idle got=%0b%0b exp=00", req_get, out_valid); end
        fq.delete();
        empty_in = 1'b1;
    endtask

    task automatic test_stream();
        int en_cyc;
        clear_stats();
        load(6, 32'h0000_00A0);
        enable = 1'b1; out_ready = 1'b1;
        en_cyc = cyc;
        for (int k = 0; k < 12; k++) step();
        tests++; if (first_req != en_cyc + 1) begin fails++; $display("FAIL stream_first_req got=%0d exp=%0d", first_req, en_cyc + 1); end
        tests++; if (req_count != 6 || last_req != first_req + 5) begin fails++; $display("FAIL stream_req_run got=%0d/%0d exp=6/%0d", req_count, last_req, first_req + 5); end
        tests++; if (first_valid != en_cyc + 3) begin fails++; $display("FAIL stream_latency got=%0d exp=%0d", first_valid, en_cyc + 3); end
        tests++; if (obs.size() != 6) begin fails++; $display("FAIL stream_count got=%0d exp=6", obs.size()); end
        for (int i = 0; i < 6 && i < obs.size(); i++) begin
            tests++; if (obs[i] !== 32'hA0 + 32'(i)) begin fails++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, obs[i], 32'hA0 + 32'(i)); end
        end
        tests++; if (word_cnt !== 4'd6) begin fails++; $display("FAIL stream_word_cnt got=%0d exp=6", word_cnt); end
        tests++; if (req_err + valid_err + busy_err + cnt_err != 0) begin fails++; $display("FAIL stream_model got=%0d exp=0", req_err + valid_err + busy_err + cnt_err); end
    endtask

    task automatic test_backpressure();
        clear_stats();
        out_ready = 1'b0;
        load(8, 32'h0000_00B0);
        for (int k = 0; k < 10; k++) step();
        tests++; if (req_count != DEPTH) begin fails++; $display("FAIL bp_requests got=%0d exp=%0d", req_count, DEPTH); end
        tests++; if (fq.size() != 4) begin fails++; $display("FAIL bp_fifo_left got=%0d exp=4", fq.size()); end
        tests++; if (req_get !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_stall got=%0b%0b exp=01", req_get, out_valid); end
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) step();
        tests++; if (obs.size() != 8) begin fails++; $display("FAIL bp_count got=%0d exp=8", obs.size()); end
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            tests++; if (obs[i] !== 32'hB0 + 32'(i)) begin fails++; $display("FAIL bp_data[%0d] got=%0h exp=%0h", i, obs[i], 32'hB0 + 32'(i)); end
        end
        tests++; if (word_cnt !== 4'd14) begin fails++; $display("FAIL bp_word_cnt got=%0d exp=14", word_cnt); end
        tests++; if (req_err + valid_err + busy_err + cnt_err != 0) begin fails++; $display("FAIL bp_model got=%0d exp=0", req_err + valid_err + busy_err + cnt_err); end
    endtask

    task automatic test_flush();
        clear_stats();
        out_ready = 1'b0;
        load(10, 32'h0000_00C0);
        step(); step();
        tests++; if (req_get !== 1'b1) begin fails++; $display("FAIL flush_pre_req got=%0b exp=1", req_get); end
        flush = 1'b1; enable = 1'b0;
        step();
        flush = 1'b0;
        tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL flush_cycle1 got=%0b%0b exp=01", out_valid, busy); end
        step();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_cycle2_busy got=%0b exp=1", busy); end
        step();
        tests++; if (busy !== 1'b0 || out_valid !== 1'b0 || req_get !== 1'b0) begin fails++; $display("FAIL flush_idle got=%0b%0b%0b exp=000", busy, out_valid, req_get); end
        tests++; if (word_cnt !== 4'd14) begin fails++; $display("FAIL flush_word_cnt got=%0d exp=14", word_cnt); end
        enable = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 15; k++) step();
        tests++; if (obs.size() != 7) begin fails++; $display("FAIL flush_resume_count got=%0d exp=7", obs.size()); end
        tests++; if (obs.size() == 0 || obs[0] !== 32'hC3) begin fails++; $display("FAIL flush_resume_word got=%0h exp=c3", (obs.size() != 0) ? obs[0] : '0); end
        tests++; if (word_cnt !== 4'd5) begin fails++; $display("FAIL flush_word_cnt_after got=%0d exp=5", word_cnt); end
        tests++; if (req_err + valid_err + busy_err + cnt_err != 0) begin fails++; $display("FAIL flush_model got=%0d exp=0", req_err + valid_err + busy_err + cnt_err); end
    endtask

    task automatic test_wrap();
        int guard;
        logic [N_BITS-1:0] base;
        reset = 1'b1; fq.delete(); empty_in = 1'b1;
        step();
        reset = 1'b0;
        clear_stats();
        enable = 1'b1;
        load(17, $urandom);
        guard = 0;
        while (obs.size() < 17 && guard < 400) begin
            out_ready = ($urandom_range(0, 1) == 1);
            step();
            guard++;
        end
        tests++; if (obs.size() != 17) begin fails++; $display("FAIL wrap_timeout got=%0d exp=17", obs.size()); end
        tests++; if (word_cnt !== 4'd1) begin fails++; $display("FAIL wrap_word_cnt got=%0d exp=1", word_cnt); end
        clear_stats();
        out_ready = 1'b0;
        base = $urandom;
        load(6, base);
        for (int k = 0; k < 8; k++) step();
        tests++; if (req_get !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL full_stall got=%0b%0b exp=01", req_get, out_valid); end
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) step();
        tests++; if (obs.size() != 6) begin fails++; $display("FAIL full_count got=%0d exp=6", obs.size()); end
        for (int i = 0; i < 6 && i < obs.size(); i++) begin
            tests++; if (obs[i] !== base + 32'(i)) begin fails++; $display("FAIL full_order[%0d] got=%0h exp=%0h", i, obs[i], base + 32'(i)); end
        end
        tests++; if (word_cnt !== 4'd7) begin fails++; $display("FAIL full_word_cnt got=%0d exp=7", word_cnt); end
        tests++; if (req_err + valid_err + busy_err + cnt_err != 0) begin fails++; $display("FAIL wrap_model got=%0d exp=0", req_err + valid_err + busy_err + cnt_err); end
    endtask

    task automatic test_reset_mid();
        int guard;
        clear_stats();
        enable = 1'b1; out_ready = 1'b0;
        load(8, 32'h0000_00D0);
        guard = 0;
        while (!(mq.size() == 3 && mfl) && guard < 20) begin
            step();
            guard++;
        end
        tests++; if (!(mq.size() == 3 && mfl)) begin fails++; $display("FAIL rstmid_setup got=%0d exp=3", mq.size()); end
        reset = 1'b1; fq.delete();
        step();
        tests++; if (req_get !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl got=%0b%0b%0b exp=000", req_get, out_valid, busy); end
        tests++; if (out_data !== '0 || word_cnt !== '0) begin fails++; $display("FAIL rstmid_data got=%0h/%0d exp=0/0", out_data, word_cnt); end
        reset = 1'b0;
        clear_stats();
        out_ready = 1'b1;
        load(4, 32'h0000_00E0);
        for (int k = 0; k < 12; k++) step();
        tests++; if (obs.size() != 4) begin fails++; $display("FAIL rstmid_count got=%0d exp=4", obs.size()); end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            tests++; if (obs[i] !== 32'hE0 + 32'(i)) begin fails++; $display("FAIL rstmid_data[%0d] got=%0h exp=%0h", i, obs[i], 32'hE0 + 32'(i)); end
        end
    endtask

    task automatic test_random();
        reset = 1'b1; fq.delete(); empty_in = 1'b1;
        step();
        reset = 1'b0;
        clear_stats();
        for (int k = 0; k < 3000; k++) begin
            enable     = ($urandom_range(0, 9) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            hold_empty = ($urandom_range(0, 4) == 0);
            if (fq.size() < 3) load(int'($urandom_range(1, 4)), $urandom);
            step();
        end
        flush = 1'b0; enable = 1'b0; out_ready = 1'b1; hold_empty = 1'b0;
        for (int k = 0; k < 20; k++) step();
        tests++; if (req_err != 0) begin fails++; $display("FAIL rand_req got=%0d exp=0", req_err); end
        tests++; if (valid_err != 0) begin fails++; $display("FAIL rand_valid got=%0d exp=0", valid_err); end
        tests++; if (busy_err != 0) begin fails++; $display("FAIL rand_busy got=%0d exp=0", busy_err); end
        tests++; if (cnt_err != 0) begin fails++; $display("FAIL rand_word_cnt got=%0d exp=0", cnt_err); end
        tests++; if (obs.size() != expd.size() || obs.size() < 50) begin fails++; $display("FAIL rand_count got=%0d exp=%0d", obs.size(), expd.size()); end
        for (int i = 0; i < obs.size() && i < expd.size(); i++) begin
            tests++; if (obs[i] !== expd[i]) begin fails++; $display("FAIL rand_data[%0d] got=%0h exp=%0h", i, obs[i], expd[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_get_drain.md
# fifo_get_drain

Get-side drain stage for the mixed-clock token-ring FIFO. It lives in the `clk_get` domain, issues `req_get` to the FIFO whenever it can accept a word, and captures the returned `data_get`. Captured words go into a small local buffer and are presented downstream on a valid/ready stream. The block also supports flush, enable and delivered-word counting, so consumers never touch `req_get`/`empty_out` timing directly.

## Interface
- `N_BITS`, 32: data width; matches FIFO `N_BITS`.
- `DEPTH`, 4: local buffer entries; power of two, ≥2.
- `CNT_W`, 16: width of delivered-word counter.

- `clk_get`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  1 = allowed to fetch from FIFO.
- `flush`  in  1  1-cycle pulse: discard buffered and in-flight words.
- `empty_in`  in  1  FIFO `empty_out`.
- `data_get`  in  N_BITS  FIFO read data.
- `req_get`  out  1  FIFO read request (combinational from state, occupancy and `empty_in`).
- `out_valid`  out  1  buffer head valid.
- `out_ready`  in  1  downstream accepts head.
- `out_data`  out  N_BITS  buffer head word (registered storage).
- `word_cnt`  out  CNT_W  words delivered downstream, wraps mod 2^CNT_W.
- `busy`  out  1  state ≠ IDLE or in-flight request pending.

## Operation
- **FSM states:** IDLE, RUN, FLUSH.
  - IDLE → RUN when `enable`=1 and `flush`=0.
  - RUN → IDLE when `enable`=0.
  - Any state → FLUSH on `flush`=1. `flush` has priority over `enable`.
  - FLUSH → IDLE once no request is in flight. Buffer is cleared on FLUSH exit.
- **FIFO read contract:** a request issued in cycle t (`req_get`=1, `empty_in`=0) makes the word appear on `data_get` during cycle t+1. The block captures it at the end of t+1.
- **In-flight tracking:** `inflight` flag is set when a request is issued and cleared on capture. At most one word is in flight per cycle; back-to-back requests are allowed (set and clear in the same cycle).
- **Request rule:** `req_get` = (state==RUN) & ~`empty_in` & (occ + `inflight` < DEPTH). The buffer can never overflow.
- **Buffer:** circular, DEPTH entries, with rd/wr pointers of log2(DEPTH) bits that wrap naturally, plus `occ` of log2(DEPTH)+1 bits.
  - `out_valid` = (occ≠0).
  - `out_data` = mem[rd_ptr].
- **Push and pop:** push on capture; pop on `out_valid`&`out_ready`. A simultaneous push and pop leaves `occ` unchanged, and this is legal even when `occ`=DEPTH.
- **Leaving RUN via `enable`=0:** the pending in-flight word is still captured. Buffered words stay deliverable while in IDLE.
- **FLUSH behaviour:**
  - `req_get`=0.
  - An in-flight word is captured and dropped.
  - `out_valid` is forced to 0.
  - Pops are ignored.
  - On exit, occ=0 and pointers are 0.
- **Counter:** `word_cnt` increments on every downstream handshake and wraps to 0 after 2^CNT_W−1. Only `reset` clears it; flush does not.

## Timing
- **Reset values:**
  - `req_get`=0, `out_valid`=0, `out_data`=0, `word_cnt`=0, `busy`=0.
  - state=IDLE, occ=0, pointers=0, inflight=0.
- **Reset mid-operation:** an in-flight word is lost. The system asserts FIFO `reset` in the same cycle.
- **Latency:**
  - First `req_get`: the cycle after `enable` rises, if the FIFO is non-empty.
  - FIFO request to `out_valid`: 2 cycles (request t, capture end of t+1, `out_valid` in t+2).
- **Throughput:** 1 word/cycle sustained while `out_ready`=1 and the FIFO is non-empty.
- **Backpressure:** requests stop when occ + inflight reaches DEPTH. With `out_ready`=0, at most DEPTH words are fetched.
- **`empty_in` mid-stream:** `req_get` drops in the same cycle `empty_in` rises. There is no speculative request.
- **FLUSH duration:** 1 cycle with no in-flight request, 2 cycles with one. `busy` falls in the first cycle of IDLE.

## Test plan
- **Reset defaults:** reset 2 cycles with FIFO preloaded with 3 words → all outputs 0 and `req_get`=0 during reset and in the first cycle after.
- **Streaming:** `enable`=1, FIFO holds 0xA0..0xA5, `out_ready`=1 → `req_get` on 6 consecutive cycles; `out_data` sequence 0xA0..0xA5 in order, 2-cycle first latency; `word_cnt`=6.
- **Backpressure:** DEPTH=4, `out_ready`=0, 8 words in FIFO → exactly 4 requests, occ=4, `req_get`=0. Then release → remaining 4 words arrive, no loss or duplication.
- **Flush mid-stream:** `flush` pulsed in the same cycle as a request → in-flight word dropped, `out_valid`=0 within 1 cycle, state IDLE after 2 cycles, `word_cnt` unchanged. Next `enable` resumes at the next FIFO word.
- **Counter wrap:** CNT_W=4, deliver 17 words → `word_cnt`=1. Also check simultaneous push and pop at occ=4 keeps occ=4 and preserves order.
- **Reset mid-operation:** `reset` asserted with occ=3 and inflight=1 → next cycle all outputs 0; after release, no stale word appears.
